// File: rtl/aes_mode_pkg.sv
// Shared types for the AES block-cipher mode controller: block width,
// mode encoding and controller state.
package aes_mode_pkg;

  localparam int unsigned BLK_W = 128;

  typedef enum logic [1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CFB = 2'd2,
    MODE_OFB = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_e;

endpackage

// File: rtl/aes_mode_xform.sv
// Mode pre/post-processing around the AES core: core input, output block and
// next chaining value for ECB/CBC/CFB-128/OFB.
module aes_mode_xform
  import aes_mode_pkg::*;
(
  input  logic [1:0]       mode_i,
  input  logic [BLK_W-1:0] in_data_i,
  input  logic [BLK_W-1:0] chain_i,
  input  logic [BLK_W-1:0] pt_i,
  input  logic [BLK_W-1:0] core_dout_i,
  output logic [BLK_W-1:0] core_din_o,
  output logic [BLK_W-1:0] out_data_o,
  output logic [BLK_W-1:0] chain_o
);

  always_comb begin
    core_din_o = in_data_i;
    out_data_o = core_dout_i;
    chain_o    = chain_i;
    case (mode_e'(mode_i))
      MODE_ECB: ;
      MODE_CBC: begin
        core_din_o = in_data_i ^ chain_i;
        chain_o    = core_dout_i;
      end
      MODE_CFB: begin
        core_din_o = chain_i;
        out_data_o = core_dout_i ^ pt_i;
        chain_o    = core_dout_i ^ pt_i;
      end
      MODE_OFB: begin
        core_din_o = chain_i;
        out_data_o = core_dout_i ^ pt_i;
        chain_o    = core_dout_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_mode_ctrl.sv
// Sequences a single-block AES core over a stream of blocks, one block in
// flight at a time, applying the selected cipher mode and IV chaining.
module aes_mode_ctrl
  import aes_mode_pkg::MODE_ECB, aes_mode_pkg::state_e, aes_mode_pkg::IDLE,
         aes_mode_pkg::ISSUE, aes_mode_pkg::WAIT, aes_mode_pkg::OUT;
#(
  parameter int unsigned BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [BLK_W-1:0] cfg_iv,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             core_start,
  output logic [BLK_W-1:0] core_din,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_dout,
  output logic             busy,
  output logic [31:0]      blk_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [BLK_W-1:0] iv_q, iv_d, chain_q, chain_d, pt_q, pt_d;
  logic [BLK_W-1:0] out_q, out_d, din_q, din_d;
  logic             last_q, last_d, err_q, err_d, rdy_q, rdy_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             cfg_now;
  logic [1:0]       mode_sel;
  logic [BLK_W-1:0] chain_sel, x_din, x_out, x_chain;

  // A config load in IDLE takes effect for a block accepted in the same cycle.
  assign cfg_now   = cfg_load && (state_q == IDLE);
  assign mode_sel  = cfg_now ? cfg_mode : mode_q;
  assign chain_sel = cfg_now ? cfg_iv : chain_q;

  aes_mode_xform u_xform (
    .mode_i      (mode_sel),
    .in_data_i   (in_data),
    .chain_i     (chain_sel),
    .pt_i        (pt_q),
    .core_dout_i (core_dout),
    .core_din_o  (x_din),
    .out_data_o  (x_out),
    .chain_o     (x_chain)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    iv_d    = iv_q;
    chain_d = chain_q;
    pt_d    = pt_q;
    last_d  = last_q;
    out_d   = out_q;
    din_d   = din_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (cfg_load) begin
      if (cfg_now) begin
        mode_d  = cfg_mode;
        iv_d    = cfg_iv;
        chain_d = cfg_iv;
        cnt_d   = '0;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          pt_d    = in_data;
          last_d  = in_last;
          din_d   = x_din;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          out_d   = x_out;
          chain_d = x_chain;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + 32'd1;
          if (last_q) chain_d = iv_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so in_ready stays low while reset is held.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_ECB;
      iv_q    <= '0;
      chain_q <= '0;
      pt_q    <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      iv_q    <= iv_d;
      chain_q <= chain_d;
      pt_q    <= pt_d;
      last_q  <= last_d;
      out_q   <= out_d;
      din_q   <= din_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready   = rdy_q;
  assign core_start = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == OUT);
  assign out_data   = out_q;
  assign out_last   = last_q;
  assign core_din   = din_q;
  assign blk_cnt    = cnt_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: XOR-key core with latency 3, a block-level mode
// model checked every cycle, plus literal ciphertext expectations.
module tb_aes_mode_ctrl;

  localparam logic [127:0] K  = 128'hFFFF0000FFFF0000FFFF0000FFFF0000;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam int unsigned  L  = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [1:0]   cfg_mode = 2'd0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_err;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_start;
  logic [127:0] core_din;
  logic         core_done;
  logic [127:0] core_dout;
  logic         busy;
  logic [31:0]  blk_cnt;

  always #5 clk = ~clk;

  aes_mode_ctrl #(.BLK_W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_load   (cfg_load),
    .cfg_mode   (cfg_mode),
    .cfg_iv     (cfg_iv),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .core_start (core_start),
    .core_din   (core_din),
    .core_done  (core_done),
    .core_dout  (core_dout),
    .busy       (busy),
    .blk_cnt    (blk_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Core model: dout = din ^ K, done pulse L cycles after the start cycle.
  logic         core_done_m = 1'b0, stray_done = 1'b0;
  logic [127:0] core_dout_m = '0, core_in = '0;
  int unsigned  core_cnt = 0;
  assign core_done = core_done_m | stray_done;
  assign core_dout = core_dout_m;

  initial forever begin
    @(posedge clk);
    #1;
    core_done_m = 1'b0;
    if (!rst_n) begin
      core_cnt = 0;
    end else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done_m = 1'b1;
          core_dout_m = core_in ^ K;
        end
      end
      if (core_start) begin
        core_cnt = L;
        core_in  = core_din;
      end
    end
  end

  // Block-level model of the controller.
  int           cyc = 0, m_hs = 0;
  bit           m_rdy = 0, m_pend = 0, m_err = 0, m_last = 0, m_ov = 0;
  logic [1:0]   m_mode = 2'd0;
  logic [127:0] m_iv = '0, m_chain = '0, m_out = '0, m_din = '0;
  logic [31:0]  m_cnt = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_rdy = 0; m_pend = 0; m_err = 0; m_mode = 2'd0;
      m_iv = '0; m_chain = '0; m_cnt = '0;
    end else begin
      m_ov = m_pend && (cyc >= m_hs + 4);
      cyc++;
      if (cfg_load) begin
        if (!m_pend) begin
          m_mode = cfg_mode; m_iv = cfg_iv; m_chain = cfg_iv; m_cnt = '0; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
      if (!m_pend && m_rdy && in_valid) begin
        case (m_mode)
          2'd0: begin m_din = in_data; m_out = in_data ^ K; end
          2'd1: begin m_din = in_data ^ m_chain; m_out = m_din ^ K; m_chain = m_out; end
          2'd2: begin m_din = m_chain; m_out = (m_chain ^ K) ^ in_data; m_chain = m_out; end
          default: begin m_din = m_chain; m_out = (m_chain ^ K) ^ in_data; m_chain = m_chain ^ K; end
        endcase
        m_pend = 1; m_hs = cyc; m_last = in_last;
      end else if (m_ov && out_ready) begin
        m_pend = 0;
        m_cnt++;
        if (m_last) m_chain = m_iv;
      end
      m_rdy = 1;
    end
  end

  // Per-cycle compare against the model.
  bit ev;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_core_din", core_din, 0);
    end else begin
      ev = m_pend && (cyc >= m_hs + 4);
      chk("in_ready", in_ready, m_rdy && !m_pend);
      chk("out_valid", out_valid, ev);
      chk("core_start", core_start, m_pend && (cyc == m_hs));
      chk("busy", busy, m_pend);
      chk("cfg_err", cfg_err, m_err);
      chk("blk_cnt", blk_cnt, m_cnt);
      if (ev) begin
        chk("out_data", out_data, m_out);
        chk("out_last", out_last, m_last);
      end
      if (m_pend && cyc <= m_hs + 3) chk("core_din", core_din, m_din);
    end
  end

  // Accepted output blocks, for literal expectations.
  logic [127:0] got_q[$];
  bit           gotl_q[$];
  initial forever begin
    @(posedge clk);
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(out_data);
      gotl_q.push_back(out_last);
    end
  end

  task automatic pop_lit(input string nm, input logic [127:0] d, input bit l);
    if (got_q.size() == 0) begin
      chk({nm, "_present"}, 0, 1);
    end else begin
      chk(nm, got_q.pop_front(), d);
      chk({nm, "_last"}, gotl_q.pop_front(), l);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [127:0] iv);
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = m; cfg_iv = iv;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input bit l, input bit with_cfg,
                      input logic [1:0] m, input logic [127:0] iv);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    if (with_cfg) begin cfg_load = 1'b1; cfg_mode = m; cfg_iv = iv; end
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_load = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_pend) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // ECB
    cfg(2'd0, '0);
    send(128'h1, 1, 0, 2'd0, '0);
    wait_idle();
    pop_lit("ecb", 128'hFFFF0000FFFF0000FFFF0000FFFF0001, 1);

    // CBC, third block restarts from IV after the last block
    cfg(2'd1, A5);
    send('0, 0, 0, 2'd0, '0);
    send('0, 1, 0, 2'd0, '0);
    send('0, 0, 0, 2'd0, '0);
    wait_idle();
    pop_lit("cbc_c0", {8{16'h5A5A, 16'hA5A5}} >> 0, 0);
    pop_lit("cbc_c1", A5, 1);
    pop_lit("cbc_c2", A5 ^ K, 0);

    // CFB with config applied in the same cycle as the first block
    send(128'h10, 0, 1, 2'd2, 128'h3);
    send(128'h10, 1, 0, 2'd0, '0);
    wait_idle();
    pop_lit("cfb_c0", 128'hFFFF0000FFFF0000FFFF0000FFFF0013, 0);
    pop_lit("cfb_c1", 128'h3, 1);

    // OFB
    cfg(2'd3, 128'h3);
    send(128'h10, 0, 0, 2'd0, '0);
    send(128'h10, 1, 0, 2'd0, '0);
    wait_idle();
    pop_lit("ofb_c0", 128'hFFFF0000FFFF0000FFFF0000FFFF0013, 0);
    pop_lit("ofb_c1", 128'h13, 1);
    chk("ofb_blk_cnt", blk_cnt, 2);

    // Output back-pressure for 10 cycles in OUT
    out_ready = 1'b0;
    send(128'h10, 1, 0, 2'd0, '0);
    repeat (14) @(negedge clk);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_blk_cnt", blk_cnt, 2);
    out_ready = 1'b1;
    wait_idle();
    chk("stall_blk_cnt_after", blk_cnt, 3);
    pop_lit("stall", 128'hFFFF0000FFFF0000FFFF0000FFFF0013, 1);

    // cfg_load while waiting on the core is rejected
    send(128'h10, 1, 0, 2'd0, '0);
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = 2'd0; cfg_iv = '1;
    @(negedge clk);
    cfg_load = 1'b0;
    wait_idle();
    chk("cfg_err_set", cfg_err, 1);
    pop_lit("cfg_wait_blk", 128'hFFFF0000FFFF0000FFFF0000FFFF0013, 1);
    cfg(2'd0, '0);
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_blk_cnt_clear", blk_cnt, 0);

    // Reset while waiting on the core, then a stray core_done
    send(128'h1, 0, 0, 2'd0, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("stray_no_output", got_q.size(), 0);
    chk("stray_out_valid", out_valid, 0);
    send(128'h5, 1, 0, 2'd0, '0);
    wait_idle();
    pop_lit("post_rst_ecb", 128'hFFFF0000FFFF0000FFFF0000FFFF0005, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
